// File: rtl/nonce_dispatcher_pkg.sv
// Shared types and widths for the nonce dispatcher.
package nonce_dispatcher_pkg;
  localparam int NONCE_W  = 32;
  localparam int HASH_W   = 256;
  localparam int REMAIN_W = 33;

  typedef enum logic [1:0] {IDLE, RUN, QUIT} state_e;
endpackage

// File: rtl/dispatch_prio_enc.sv
// Lowest-index one-hot priority encoder.
module dispatch_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         vld_o
);
  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
  assign vld_o = |req_i;
endmodule

// File: rtl/nonce_dispatcher.sv
// Hands nonces from an inclusive wrapping range to idle hashing modules and
// captures the first winning nonce/hash.
module nonce_dispatcher
  import nonce_dispatcher_pkg::*;
#(
  parameter int NUM_HM = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NONCE_W-1:0]       nonce_start,
  input  logic [NONCE_W-1:0]       nonce_end,
  input  logic [NUM_HM-1:0]        hm_done,
  input  logic [NUM_HM-1:0]        hm_valid,
  input  logic [NUM_HM*HASH_W-1:0] hm_hash,
  output logic [NUM_HM-1:0]        hm_begin,
  output logic [NUM_HM-1:0]        hm_quit,
  output logic [NUM_HM*NONCE_W-1:0] hm_nonce,
  output logic                     busy,
  output logic                     found,
  output logic                     exhausted,
  output logic                     search_done,
  output logic [NONCE_W-1:0]       found_nonce,
  output logic [HASH_W-1:0]        found_hash
);
  state_e                           state_q, state_d;
  logic [NUM_HM-1:0]                mask_q, mask_d, mask_cmp, inflight;
  logic [NONCE_W-1:0]               next_q, next_d;
  logic [REMAIN_W-1:0]              remain_q, remain_d;
  logic [NUM_HM-1:0][NONCE_W-1:0]   nonce_q, nonce_d;
  logic [NUM_HM-1:0]                begin_q, begin_d, quit_q, quit_d;
  logic                             busy_q, busy_d, found_q, found_d;
  logic                             exh_q, exh_d, sdone_q, sdone_d;
  logic [NONCE_W-1:0]               fnonce_q, fnonce_d, win_nonce;
  logic [HASH_W-1:0]                fhash_q, fhash_d, win_hash;
  logic [NUM_HM-1:0]                win_req, win_gnt, free_req, disp_gnt;
  logic                             win_vld, disp_vld;

  assign win_req  = mask_q & hm_done & hm_valid;
  assign free_req = ~mask_q & ~hm_done;
  assign mask_cmp = mask_q & ~(hm_done & ~hm_valid);
  // Modules reporting done this cycle are no longer in flight and get no quit.
  assign inflight = mask_q & ~hm_done;

  dispatch_prio_enc #(.N(NUM_HM)) u_win  (.req_i(win_req),  .gnt_o(win_gnt),  .vld_o(win_vld));
  dispatch_prio_enc #(.N(NUM_HM)) u_disp (.req_i(free_req), .gnt_o(disp_gnt), .vld_o(disp_vld));

  always_comb begin
    win_nonce = '0;
    win_hash  = '0;
    for (int i = 0; i < NUM_HM; i++)
      if (win_gnt[i]) begin
        win_nonce = nonce_q[i];
        win_hash  = hm_hash[i*HASH_W +: HASH_W];
      end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    next_d   = next_q;
    remain_d = remain_q;
    nonce_d  = nonce_q;
    begin_d  = '0;
    quit_d   = '0;
    busy_d   = busy_q;
    found_d  = found_q;
    exh_d    = exh_q;
    sdone_d  = 1'b0;
    fnonce_d = fnonce_q;
    fhash_d  = fhash_q;
    case (state_q)
      IDLE: if (start) begin
        next_d   = nonce_start;
        remain_d = {1'b0, nonce_end - nonce_start} + REMAIN_W'(1);
        found_d  = 1'b0;
        exh_d    = 1'b0;
        busy_d   = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (abort) begin
          quit_d  = inflight;
          mask_d  = inflight;
          state_d = QUIT;
        end else if (win_vld) begin
          found_d  = 1'b1;
          fnonce_d = win_nonce;
          fhash_d  = win_hash;
          quit_d   = inflight;
          mask_d   = inflight;
          state_d  = QUIT;
        end else if (remain_q == '0 && mask_q == '0) begin
          exh_d   = 1'b1;
          sdone_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          mask_d = mask_cmp;
          if (remain_q != '0 && disp_vld) begin
            mask_d   = mask_cmp | disp_gnt;
            begin_d  = disp_gnt;
            next_d   = next_q + NONCE_W'(1);
            remain_d = remain_q - REMAIN_W'(1);
            for (int i = 0; i < NUM_HM; i++)
              if (disp_gnt[i]) nonce_d[i] = next_q;
          end
        end
      end
      QUIT: begin
        mask_d  = '0;
        sdone_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      next_q   <= '0;
      remain_q <= '0;
      nonce_q  <= '0;
      begin_q  <= '0;
      quit_q   <= '0;
      busy_q   <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      sdone_q  <= 1'b0;
      fnonce_q <= '0;
      fhash_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      next_q   <= next_d;
      remain_q <= remain_d;
      nonce_q  <= nonce_d;
      begin_q  <= begin_d;
      quit_q   <= quit_d;
      busy_q   <= busy_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      sdone_q  <= sdone_d;
      fnonce_q <= fnonce_d;
      fhash_q  <= fhash_d;
    end
  end

  assign hm_begin    = begin_q;
  assign hm_quit     = quit_q;
  assign hm_nonce    = nonce_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exh_q;
  assign search_done = sdone_q;
  assign found_nonce = fnonce_q;
  assign found_hash  = fhash_q;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench: one single-module and one four-module dispatcher on a shared clock/reset.
module tb_nonce_dispatcher;
  localparam logic [255:0] H0 = {8{32'hA0A0_0000}};
  localparam logic [255:0] H1 = {8{32'hB1B1_1111}};
  localparam logic [255:0] H2 = {8{32'hC2C2_2222}};
  localparam logic [255:0] H3 = {8{32'hD3D3_3333}};

  logic clk = 1'b0;
  logic n_rst;
  int   nvec = 0;
  int   nerr = 0;

  // single-module instance
  logic         s1_start, s1_abort;
  logic [31:0]  s1_ns, s1_ne;
  logic [0:0]   d1_done, d1_valid;
  logic [255:0] d1_hash;
  logic [0:0]   o1_begin, o1_quit;
  logic [31:0]  o1_nonce, o1_fnonce;
  logic         o1_busy, o1_found, o1_exh, o1_sdone;
  logic [255:0] o1_fhash;

  // four-module instance
  logic          s4_start, s4_abort;
  logic [31:0]   s4_ns, s4_ne;
  logic [3:0]    d4_done, d4_valid;
  logic [1023:0] d4_hash;
  logic [3:0]    o4_begin, o4_quit;
  logic [127:0]  o4_nonce;
  logic [31:0]   o4_fnonce;
  logic          o4_busy, o4_found, o4_exh, o4_sdone;
  logic [255:0]  o4_fhash;

  always #5 clk = ~clk;

  nonce_dispatcher #(.NUM_HM(1)) u1 (
    .clk(clk), .n_rst(n_rst), .start(s1_start), .abort(s1_abort),
    .nonce_start(s1_ns), .nonce_end(s1_ne), .hm_done(d1_done), .hm_valid(d1_valid),
    .hm_hash(d1_hash), .hm_begin(o1_begin), .hm_quit(o1_quit), .hm_nonce(o1_nonce),
    .busy(o1_busy), .found(o1_found), .exhausted(o1_exh), .search_done(o1_sdone),
    .found_nonce(o1_fnonce), .found_hash(o1_fhash));

  nonce_dispatcher #(.NUM_HM(4)) u4 (
    .clk(clk), .n_rst(n_rst), .start(s4_start), .abort(s4_abort),
    .nonce_start(s4_ns), .nonce_end(s4_ne), .hm_done(d4_done), .hm_valid(d4_valid),
    .hm_hash(d4_hash), .hm_begin(o4_begin), .hm_quit(o4_quit), .hm_nonce(o4_nonce),
    .busy(o4_busy), .found(o4_found), .exhausted(o4_exh), .search_done(o4_sdone),
    .found_nonce(o4_fnonce), .found_hash(o4_fhash));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-module search; every dispatched nonce completes without a valid hash.
  task automatic run1(input logic [31:0] ns, input logic [31:0] ne, input int cnt);
    logic [31:0] en;
    s1_ns = ns; s1_ne = ne; s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    chk("r1_busy", 256'(o1_busy), 256'd1);
    chk("r1_exh_clr", 256'(o1_exh), 256'd0);
    for (int k = 0; k < cnt; k++) begin
      en = ns + 32'(k);
      tick();
      chk("r1_begin", 256'(o1_begin), 256'd1);
      chk("r1_nonce", 256'(o1_nonce), 256'(en));
      d1_done = 1'b1;
      tick();
      chk("r1_begin_idle", 256'(o1_begin), 256'd0);
      d1_done = 1'b0;
    end
    tick();
    chk("r1_exh", 256'(o1_exh), 256'd1);
    chk("r1_sdone", 256'(o1_sdone), 256'd1);
    chk("r1_busy_clr", 256'(o1_busy), 256'd0);
    chk("r1_found", 256'(o1_found), 256'd0);
    chk("r1_no_begin", 256'(o1_begin), 256'd0);
    tick();
    chk("r1_sdone_pulse", 256'(o1_sdone), 256'd0);
    chk("r1_exh_sticky", 256'(o1_exh), 256'd1);
  endtask

  // Start a 4-module search and let all four modules receive their first nonce.
  task automatic start4(input logic [31:0] ns, input logic [31:0] ne);
    logic [3:0]  eb;
    logic [31:0] en;
    s4_ns = ns; s4_ne = ne; s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    chk("s4_busy", 256'(o4_busy), 256'd1);
    chk("s4_found_clr", 256'(o4_found), 256'd0);
    for (int i = 0; i < 4; i++) begin
      eb = 4'b0001 << i;
      en = ns + 32'(i);
      tick();
      chk("s4_begin", 256'(o4_begin), 256'(eb));
      chk("s4_nonce", 256'(o4_nonce[32*i +: 32]), 256'(en));
    end
  endtask

  initial begin
    n_rst = 1'b0;
    s1_start = 1'b0; s1_abort = 1'b0; s1_ns = '0; s1_ne = '0;
    d1_done = '0; d1_valid = '0; d1_hash = H3;
    s4_start = 1'b0; s4_abort = 1'b0; s4_ns = '0; s4_ne = '0;
    d4_done = '0; d4_valid = '0; d4_hash = {H3, H2, H1, H0};
    #12;
    chk("rst_busy", 256'(o4_busy), 256'd0);
    chk("rst_nonce", 256'(o4_nonce), 256'd0);
    chk("rst_flags", 256'({o4_found, o4_exh, o4_sdone, o4_begin, o4_quit}), 256'd0);
    chk("rst_fhash", o4_fhash, 256'd0);
    n_rst = 1'b1;

    // single module, 5..7
    run1(32'd5, 32'd7, 3);

    // range 0..9, module 2 wins with nonce 6
    start4(32'd0, 32'd9);
    d4_done = 4'b0011;
    tick();
    chk("t2_no_disp", 256'(o4_begin), 256'd0);
    d4_done = 4'b0000;
    tick();
    chk("t2_begin0", 256'(o4_begin), 256'(4'b0001));
    chk("t2_nonce0", 256'(o4_nonce[31:0]), 256'd4);
    tick();
    chk("t2_begin1", 256'(o4_begin), 256'(4'b0010));
    chk("t2_nonce1", 256'(o4_nonce[63:32]), 256'd5);
    d4_done = 4'b0100;
    tick();
    chk("t2_freed_wait", 256'(o4_begin), 256'd0);
    d4_done = 4'b0000;
    tick();
    chk("t2_begin2", 256'(o4_begin), 256'(4'b0100));
    chk("t2_nonce2", 256'(o4_nonce[95:64]), 256'd6);
    d4_done = 4'b0100; d4_valid = 4'b0100;
    tick();
    d4_done = 4'b0000; d4_valid = 4'b0000;
    chk("t2_found", 256'(o4_found), 256'd1);
    chk("t2_fnonce", 256'(o4_fnonce), 256'd6);
    chk("t2_fhash", o4_fhash, H2);
    chk("t2_quit", 256'(o4_quit), 256'(4'b1011));
    chk("t2_no_begin", 256'(o4_begin), 256'd0);
    chk("t2_sdone_early", 256'(o4_sdone), 256'd0);
    tick();
    chk("t2_sdone", 256'(o4_sdone), 256'd1);
    chk("t2_busy_clr", 256'(o4_busy), 256'd0);
    chk("t2_quit_pulse", 256'(o4_quit), 256'd0);
    chk("t2_no_begin2", 256'(o4_begin), 256'd0);
    chk("t2_found_sticky", 256'(o4_found), 256'd1);

    // modules 1 and 2 win together: lowest index kept
    start4(32'd100, 32'd199);
    d4_done = 4'b0110; d4_valid = 4'b0110;
    tick();
    d4_done = 4'b0000; d4_valid = 4'b0000;
    chk("t3_found", 256'(o4_found), 256'd1);
    chk("t3_fnonce", 256'(o4_fnonce), 256'd101);
    chk("t3_fhash", o4_fhash, H1);
    chk("t3_quit", 256'(o4_quit), 256'(4'b1001));
    tick();
    chk("t3_sdone", 256'(o4_sdone), 256'd1);

    // wrap across 0xFFFFFFFF, then a single-nonce range
    run1(32'hFFFF_FFFE, 32'h0000_0001, 4);
    run1(32'h10, 32'h10, 1);

    // abort beats a same-cycle winner
    start4(32'd0, 32'd9);
    s4_abort = 1'b1; d4_done = 4'b0010; d4_valid = 4'b0010;
    tick();
    s4_abort = 1'b0; d4_done = 4'b0000; d4_valid = 4'b0000;
    chk("t5_found", 256'(o4_found), 256'd0);
    chk("t5_exh", 256'(o4_exh), 256'd0);
    chk("t5_quit", 256'(o4_quit), 256'(4'b1101));
    chk("t5_no_begin", 256'(o4_begin), 256'd0);
    chk("t5_sdone_early", 256'(o4_sdone), 256'd0);
    tick();
    chk("t5_sdone", 256'(o4_sdone), 256'd1);
    chk("t5_busy_clr", 256'(o4_busy), 256'd0);
    chk("t5_found_clr", 256'(o4_found), 256'd0);
    chk("t5_fnonce_keep", 256'(o4_fnonce), 256'd101);
    s4_abort = 1'b1;
    tick();
    s4_abort = 1'b0;
    chk("t5_idle_abort", 256'({o4_busy, o4_sdone, o4_quit}), 256'd0);

    // asynchronous reset mid-run, then a clean restart
    s4_ns = 32'd0; s4_ne = 32'd9; s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    tick();
    tick();
    chk("t6_pre_begin", 256'(o4_begin), 256'(4'b0010));
    n_rst = 1'b0;
    #1;
    chk("t6_busy", 256'(o4_busy), 256'd0);
    chk("t6_begin", 256'(o4_begin), 256'd0);
    chk("t6_nonce", 256'(o4_nonce), 256'd0);
    chk("t6_fnonce", 256'(o4_fnonce), 256'd0);
    chk("t6_fhash", o4_fhash, 256'd0);
    #1;
    n_rst = 1'b1;
    s4_ns = 32'd20; s4_ne = 32'd29; s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    chk("t6_restart_busy", 256'(o4_busy), 256'd1);
    tick();
    chk("t6_restart_begin", 256'(o4_begin), 256'(4'b0001));
    chk("t6_restart_nonce", 256'(o4_nonce[31:0]), 256'd20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Schedules a nonce search across NUM_HM parallel hashing modules.
- Hands each idle module the next nonce in an inclusive, wrapping 32-bit range and pulses its begin_hash.
- Collects hash_done/valid_hash_flag, captures the first winning nonce and hash, then quits all in-flight modules.
- Sits between the miner control/communication logic and the hashing-module array; a header formatter builds each module's data_to_hash from hm_nonce.

Parameters:
- NUM_HM, 4: number of hashing modules managed (1..16).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a search; ignored unless busy=0
- abort  in  1  pulse: cancel the current search
- nonce_start  in  32  first nonce, inclusive; sampled on accepted start
- nonce_end  in  32  last nonce, inclusive; sampled on accepted start
- hm_done  in  NUM_HM  per-module hash_done
- hm_valid  in  NUM_HM  per-module valid_hash_flag
- hm_hash  in  NUM_HM*256  per-module valid_hash; module i occupies bits [256i+255:256i]
- hm_begin  out  NUM_HM  per-module begin_hash, one-cycle pulse
- hm_quit  out  NUM_HM  per-module quit_hash, one-cycle pulse
- hm_nonce  out  NUM_HM*32  nonce assigned to module i; held until its next dispatch
- busy  out  1  search in progress
- found  out  1  sticky until next accepted start: winning hash captured
- exhausted  out  1  sticky until next accepted start: range finished with no valid hash
- search_done  out  1  one-cycle pulse when the search ends (found, exhausted or abort)
- found_nonce  out  32  winning nonce
- found_hash  out  256  winning hash

Behaviour:
- Reset: all outputs 0, including hm_nonce, found_nonce and found_hash. State=IDLE; module busy mask=0.
- All outputs are registered.
- States: IDLE, RUN, QUIT.

IDLE:
- An accepted start loads next=nonce_start and remaining=(nonce_end-nonce_start)+1 as a 33-bit value (2^32 when end=start-1 mod 2^32).
- It also clears found and exhausted, sets busy, and goes to RUN.
- start=nonce_end gives exactly 1 nonce.

RUN, each cycle:
- Completion: for each module i with mask[i]=1 and hm_done[i]=1:
  - if hm_valid[i]=1, it is a winner;
  - otherwise clear mask[i].
  - A held-high hm_done counts once.
- Winner:
  - Lowest-index winner is captured: found_nonce=hm_nonce[i], found_hash=hm_hash[i].
  - Set found; go to QUIT.
  - Other simultaneous winners are discarded.
- Dispatch: at most one per cycle, only if remaining!=0 and no winner this cycle.
  - Eligible: lowest-index module with mask=0 and hm_done=0, evaluated on registered mask.
  - Action: hm_nonce[i]=next, hm_begin[i]=1 for one cycle, mask[i]=1, next=next+1 (wraps 0xFFFFFFFF->0), remaining=remaining-1.
  - A module freed this cycle is eligible no earlier than the next cycle.
- Exhaustion: remaining=0 and mask=0 with no winner -> set exhausted, pulse search_done, clear busy, go to IDLE.
- Abort: goes to QUIT without setting found.
  - Abort beats a same-cycle winner; that result is discarded.
  - Abort beats dispatch.

QUIT (one cycle):
- hm_quit[i]=1 for every i with mask[i]=1.
- Then clear mask, pulse search_done, clear busy, go to IDLE.

Timing and other rules:
- Latency: start accepted at edge t -> first hm_begin at cycle t+1.
- NUM_HM dispatches complete by cycle t+NUM_HM.
- Winner seen at edge t -> found=1 and hm_quit asserted at cycle t+1; search_done at t+2.
- start during RUN/QUIT: ignored.
- abort in IDLE: ignored.
- Reset mid-run: everything returns to reset values immediately. No hm_quit is issued; the modules are reset by the same n_rst.

Decomposition:
- Package nonce_dispatcher_pkg holds:
  - state enum (IDLE, RUN, QUIT);
  - NONCE_W=32, HASH_W=256, REMAIN_W=33.
- One sub-module: dispatch_prio_enc, a parameterised lowest-index one-hot priority encoder with a valid output. It is instantiated twice: once for the dispatch choice, once for the winner choice.

Test Plan:
- NUM_HM=1, range 5..7, done without valid each time -> hm_nonce 5,6,7 dispatched in order; exhausted=1; search_done pulse; found=0.
- NUM_HM=4, range 0..9, valid on the module holding nonce 6 -> found_nonce=6, found_hash=that module's hm_hash; hm_quit to all other busy modules; no further hm_begin.
- NUM_HM=4, modules 1 and 2 both done+valid in the same cycle -> module 1's nonce and hash captured.
- Range 0xFFFFFFFE..0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 then exhausted; start=end=0x10 -> exactly one begin.
- abort in the same cycle as a valid done -> found=0, exhausted=0; hm_quit to busy modules; search_done 1 cycle later.
- n_rst asserted during RUN -> all outputs 0 asynchronously; a subsequent start works from IDLE normally.
